// File: rtl/word_uart_tx_pkg.sv
// Shared UART definitions: line states, idle level and frame length.
// The receiver will import the same package.
package word_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   FRAME_BITS      = 10;

endpackage

// File: rtl/register.sv
// 16-bit load-enabled word register; the data path carries no reset.
module Register (
  input  logic        clk,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (load) out <= in;
  end

endmodule

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = ~clear & (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (clear | bit_end) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/word_uart_tx.sv
// Sends a latched 16-bit word as two 8N1 frames, low byte first.
// state | meaning
// IDLE  | line high, ready for a word
// START | start bit (low) of the current byte
// DATA  | data bit {byte, bit} of the held word, LSB first
// STOP  | stop bit (high); then byte 1 or back to IDLE
import word_uart_tx_pkg::*;

module word_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  output logic        ready,
  output logic        busy,
  output logic        tx
);

  uart_state_t state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        byte_cnt, byte_cnt_nxt;
  logic [15:0] hold;
  logic        accept;
  logic        bit_end;

  assign ready  = (state == IDLE);
  assign busy   = ~ready;
  assign accept = load & ready;

  Register u_hold (
    .clk  (clk),
    .in   (in),
    .load (accept),
    .out  (hold)
  );

  // Baud counter sits at zero while idle so a new start bit gets a full period.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (ready),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    tx           = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        bit_cnt_nxt  = 3'd0;
        byte_cnt_nxt = 1'b0;
        if (accept) state_nxt = START;
      end
      START: begin
        tx = ~UART_IDLE_LEVEL;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = hold[{byte_cnt, bit_cnt}];
        if (bit_end) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_cnt) begin
            byte_cnt_nxt = 1'b1;
            state_nxt    = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Self-checking bench for word_uart_tx with CLKS_PER_BIT=4: directed frame tables,
// back-to-back, mid-frame reset, and a randomized run against a line-level model.
import word_uart_tx_pkg::*;

module tb_word_uart_tx;

  localparam int CPB        = 4;
  localparam int WORD_CYCLES = 2 * FRAME_BITS * CPB;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        ready;
  logic        busy;
  logic        tx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] dec_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] word;
    string       seq;
    string       name;
  } vec_t;

  vec_t vecs[4];

  word_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .ready (ready),
    .busy  (busy),
    .tx    (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // Line decoder: samples mid-bit after each falling start edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        dec_q.push_back(b);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line bit n (0..19) for a word: start, 8 data LSB first, stop, per byte.
  function automatic logic frame_bit(input logic [15:0] w, input int n);
    logic [19:0] seq;
    seq = {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
    return seq[n];
  endfunction

  task automatic check_idle(input string name);
    check({name, "_tx"}, tx, 1'b1);
    check({name, "_ready"}, ready, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge where ready
  // is due back (cycle 80), or at cycle abort_at if that comes first.
  task automatic send_word(input logic [15:0] w, input string seq, input string name,
                           input bit jam, input int abort_at);
    check({name, "_pre_ready"}, ready, 1'b1);
    in   = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    in   = ~w;
    for (int k = 0; k < WORD_CYCLES; k++) begin
      if (k == abort_at) return;
      check($sformatf("%s_tx_k%0d", name, k), tx, (seq[k / CPB] == "1") ? 1'b1 : 1'b0);
      check($sformatf("%s_ready_k%0d", name, k), ready, 1'b0);
      check($sformatf("%s_busy_k%0d", name, k), busy, 1'b1);
      if (jam) begin
        in   = 16'hFFFF;
        load = (k % 10 == 9);
      end
      @(negedge clk);
    end
    load = 1'b0;
    check_idle({name, "_end"});
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] e[4];
    e = '{b0, b1, b2, b3};
    check({name, "_count"}, dec_q.size(), n);
    for (int i = 0; i < n && i < dec_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), dec_q[i], e[i]);
  endtask

  initial begin
    int left;
    int lb;
    int n_acc;
    logic [15:0] cur;
    logic exp_ready;
    logic exp_tx;

    vecs[0] = '{16'hA55A, "00101101010101001011", "a55a"};
    vecs[1] = '{16'h0001, "01000000010000000001", "w0001"};
    vecs[2] = '{16'h1234, "00010110010010010001", "w1234"};
    vecs[3] = '{16'hFFFF, "01111111110111111111", "wffff"};

    reset = 1'b1;
    load  = 1'b0;
    in    = 16'h0000;

    // 1: reset and idle line
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
    end

    // 2: frame tables, including the model function against the literal table
    foreach (vecs[i]) begin
      for (int n = 0; n < 2 * FRAME_BITS; n++)
        check($sformatf("model_%s_bit%0d", vecs[i].name, n), frame_bit(vecs[i].word, n),
              (vecs[i].seq[n] == "1") ? 1'b1 : 1'b0);
      dec_q.delete();
      send_word(vecs[i].word, vecs[i].seq, vecs[i].name, 1'b0, -1);
      expect_bytes({vecs[i].name, "_dec"}, vecs[i].word[7:0], vecs[i].word[15:8], 8'h00, 8'h00, 2);
      repeat (3) @(negedge clk);
    end

    // 3: loads during busy are ignored and the latched word is what goes out
    dec_q.delete();
    send_word(16'h1234, vecs[2].seq, "jam", 1'b1, -1);
    expect_bytes("jam_dec", 8'h34, 8'h12, 8'h00, 8'h00, 2);
    repeat (3) @(negedge clk);

    // 4: back-to-back words with a single idle cycle in between
    dec_q.delete();
    send_word(16'h00FF, "01111111110000000001", "b2b_a", 1'b0, -1);
    send_word(16'hFF00, "00000000010111111111", "b2b_b", 1'b0, -1);
    @(negedge clk);
    expect_bytes("b2b_dec", 8'hFF, 8'h00, 8'h00, 8'hFF, 4);
    repeat (3) @(negedge clk);

    // 5: reset in the middle of byte 0 data
    send_word(16'hBEEF, "01111011110011111011", "rst", 1'b0, 30);
    check("rst_mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    check_idle("rst_held");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_idle($sformatf("rst_after%0d", i));
    end
    dec_q.delete();
    send_word(16'h0001, vecs[1].seq, "post_rst", 1'b0, -1);
    expect_bytes("post_rst_dec", 8'h01, 8'h00, 8'h00, 8'h00, 2);
    repeat (3) @(negedge clk);

    // 6: random words and gaps against the line-level model
    dec_q.delete();
    exp_q.delete();
    left  = 0;
    n_acc = 0;
    cur   = 16'h0000;
    for (int cyc = 0; cyc < 40000 && n_acc < 200; cyc++) begin
      lb        = left;
      exp_ready = (lb == 0);
      if (left > 0) left--;
      exp_tx = exp_ready ? 1'b1 : frame_bit(cur, (WORD_CYCLES - lb) / CPB);
      if (ready !== exp_ready)
        check($sformatf("rand_ready_c%0d", cyc), ready, exp_ready);
      if (tx !== exp_tx)
        check($sformatf("rand_tx_c%0d", cyc), tx, exp_tx);
      if (busy !== ~exp_ready)
        check($sformatf("rand_busy_c%0d", cyc), busy, ~exp_ready);
      load = ($urandom_range(0, 2) == 0);
      in   = 16'($urandom);
      if (load && exp_ready) begin
        cur  = in;
        left = WORD_CYCLES;
        n_acc++;
        exp_q.push_back(in[7:0]);
        exp_q.push_back(in[15:8]);
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("rand_accepted", n_acc, 200);
    repeat (WORD_CYCLES + 5) @(negedge clk);
    check("rand_idle_ready", ready, 1'b1);
    check("rand_dec_count", dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
      if (dec_q[i] !== exp_q[i])
        check($sformatf("rand_byte%0d", i), dec_q[i], exp_q[i]);
    check("rand_first_byte", (dec_q.size() > 0) ? dec_q[0] : 8'hxx,
          (exp_q.size() > 0) ? exp_q[0] : 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
